// File: rtl/bin_onehot_pkg.sv
// Shared definitions for the binary/one-hot converter: mode codes, buffer states
// and the width-generic decode/encode/legality helpers.
package bin_onehot_pkg;

  localparam logic MODE_B2O = 1'b0;
  localparam logic MODE_O2B = 1'b1;

  // Helpers work on the widest supported vector; callers size-cast in and out.
  localparam int MAX_W = 8;
  localparam int MAX_N = 2 ** MAX_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

  function automatic logic [MAX_N-1:0] onehot_decode(input logic [MAX_W-1:0] idx,
                                                     input logic zero_null);
    logic [MAX_N-1:0] vec;
    vec = '0;
    if (!(zero_null && (idx == '0))) vec[idx] = 1'b1;
    return vec;
  endfunction

  function automatic logic [MAX_W-1:0] onehot_encode(input logic [MAX_N-1:0] vec);
    logic [MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (vec[i]) idx = idx | MAX_W'(i);
    end
    return idx;
  endfunction

  // Mode 0: any bit at or above w is illegal. Mode 1: needs exactly one bit,
  // or none when zero_null is set. Uses a seen/multi chain instead of a popcount.
  function automatic logic conv_illegal(input logic mode, input logic [MAX_N-1:0] vec,
                                        input int w, input logic zero_null);
    logic upper;
    logic seen;
    logic multi;
    upper = 1'b0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i >= w) upper = upper | vec[i];
      if (vec[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    if (mode == MODE_B2O) return upper;
    return multi || (!seen && !zero_null);
  endfunction

endpackage

// File: rtl/bin_onehot_skid.sv
// Two-entry valid/ready buffer: an output register plus one skid register, so
// in_ready depends only on registered state.
module bin_onehot_skid
  import bin_onehot_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  buf_state_t    state;
  logic [DW-1:0] skid_data;
  logic          accept;
  logic          xfer;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data <= in_data;
            state    <= ONE;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            out_data <= in_data;
          end else if (accept) begin
            state <= TWO;
          end else if (xfer) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (xfer) begin
            out_data <= skid_data;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Skid payload needs no reset: it is only read in TWO, which reset leaves.
  always_ff @(posedge clk) begin
    if ((state == ONE) && accept && !xfer) skid_data <= in_data;
  end

endmodule

// File: rtl/bin_onehot_conv.sv
// Pipelined binary <-> one-hot converter with per-transaction mode select,
// illegal-input flagging and a saturating error counter.
module bin_onehot_conv
  import bin_onehot_pkg::*;
#(
  parameter int  W         = 2,
  parameter bit  ZERO_NULL = 1'b0,
  parameter int  CW        = 8,
  localparam int N         = 2 ** W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_err,
  input  logic          err_clr,
  output logic [CW-1:0] err_cnt
);

  logic         illegal;
  logic [N-1:0] conv;
  logic         accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    illegal = conv_illegal(in_mode, MAX_N'(in_data), W, ZERO_NULL);
    if (in_mode == MODE_B2O) conv = N'(onehot_decode(MAX_W'(in_data[W-1:0]), ZERO_NULL));
    else                     conv = N'(onehot_encode(MAX_N'(in_data)));
    if (illegal) conv = '0;
  end

  // Stage boundary: converted payload and its error flag enter the buffer together.
  bin_onehot_skid #(
    .DW(N + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({illegal, conv}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({out_err, out_data})
  );

  // A clear coinciding with an illegal accept keeps that accept counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && illegal) begin
      if (err_clr)              err_cnt <= CW'(1);
      else if (err_cnt != '1)   err_cnt <= err_cnt + 1'b1;
    end else if (err_clr) begin
      err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_bin_onehot_conv.sv
// Scoreboard bench: two converters (ZERO_NULL 0 and 1) share one stimulus stream
// and are checked against an independent reference model.
module tb_bin_onehot_conv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       out_ready = 1'b1;
  logic       err_clr = 1'b0;

  logic       in_ready0, in_ready1, ov0, ov1, oe0, oe1;
  logic [3:0] od0, od1;
  logic [1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    logic [4:0] e0;
    logic [4:0] e1;
    int         c;
  } exp_t;

  exp_t       q[$];
  logic [1:0] mc0 = 2'd0;
  logic [1:0] mc1 = 2'd0;

  bin_onehot_conv #(.W(2), .ZERO_NULL(1'b0), .CW(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_mode(in_mode),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_err(oe0), .err_clr(err_clr), .err_cnt(cnt0));

  bin_onehot_conv #(.W(2), .ZERO_NULL(1'b1), .CW(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_mode(in_mode),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_err(oe1), .err_clr(err_clr), .err_cnt(cnt1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference result as {err, data[3:0]}.
  function automatic logic [4:0] model(input logic mode, input logic [3:0] d, input bit zn);
    if (mode == 1'b0) begin
      if (d[3:2] != 2'b00) return 5'b10000;
      if (zn && (d[1:0] == 2'b00)) return 5'b00000;
      return {1'b0, 4'b0001 << d[1:0]};
    end
    case (d)
      4'b0001: return 5'd0;
      4'b0010: return 5'd1;
      4'b0100: return 5'd2;
      4'b1000: return 5'd3;
      4'b0000: return zn ? 5'd0 : 5'b10000;
      default: return 5'b10000;
    endcase
  endfunction

  function automatic logic [1:0] next_cnt(input logic [1:0] c, input logic acc_ill,
                                          input logic clr);
    if (acc_ill) return clr ? 2'd1 : ((c == 2'd3) ? c : c + 2'd1);
    return clr ? 2'd0 : c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop on transfer, track the expected counters.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [4:0] x0, x1;
    if (rst) begin
      q.delete();
      mc0 <= 2'd0;
      mc1 <= 2'd0;
    end else begin
      chk("err_cnt_zn0", {30'b0, cnt0}, {30'b0, mc0});
      chk("err_cnt_zn1", {30'b0, cnt1}, {30'b0, mc1});
      if (ov0 && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", {31'b0, ov0}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_zn0", {27'b0, oe0, od0}, {27'b0, e.e0});
          chk("out_zn1", {27'b0, oe1, od1}, {27'b0, e.e1});
          if (lat_chk) chk("latency", cyc - e.c, 32'd1);
        end
      end
      if (in_valid && in_ready0) begin
        x0 = model(in_mode, in_data, 1'b0);
        x1 = model(in_mode, in_data, 1'b1);
        q.push_back('{x0, x1, cyc});
        mc0 <= next_cnt(mc0, x0[4], err_clr);
        mc1 <= next_cnt(mc1, x1[4], err_clr);
      end else begin
        mc0 <= next_cnt(mc0, 1'b0, err_clr);
        mc1 <= next_cnt(mc1, 1'b0, err_clr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [3:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    for (int i = 0; i < 40; i++) begin
      if (in_ready0) begin
        step();
        return;
      end
      step();
    end
    chk("send_timeout_in_ready", {31'b0, in_ready0}, 32'd1);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0] d;
    logic       m;

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", {31'b0, ov0}, 32'd0);
    chk("rst_out_data", {28'b0, od0}, 32'd0);
    chk("rst_out_err", {31'b0, oe0}, 32'd0);
    chk("rst_err_cnt", {30'b0, cnt0}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {31'b0, in_ready0}, 32'd1);

    // Mode 0
    send(1'b0, 4'h2);
    send(1'b0, 4'h0);
    send(1'b0, 4'b0101);
    in_valid = 1'b0;
    repeat (2) step();
    chk("mode0_err_cnt", {30'b0, cnt0}, 32'd1);

    // Mode 1
    send(1'b1, 4'b1000);
    send(1'b1, 4'b0110);
    send(1'b1, 4'b0000);
    in_valid = 1'b0;
    repeat (2) step();
    chk("mode1_err_cnt_zn0", {30'b0, cnt0}, 32'd3);
    chk("mode1_err_cnt_zn1", {30'b0, cnt1}, 32'd2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err_cnt", {30'b0, cnt0}, 32'd0);

    // Backpressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    send(1'b0, 4'h1);
    send(1'b0, 4'h3);
    chk("bp_in_ready_low", {31'b0, in_ready0}, 32'd0);
    in_mode = 1'b1;
    in_data = 4'b0100;
    repeat (2) step();
    chk("bp_hold_valid", {31'b0, ov0}, 32'd1);
    chk("bp_hold_data", {28'b0, od0}, 32'h2);
    out_ready = 1'b1;
    send(1'b1, 4'b0100);
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_drained", q.size(), 32'd0);

    // Counter saturation and clear
    repeat (5) send(1'b0, 4'b1000);
    in_valid = 1'b0;
    step();
    chk("sat_err_cnt_zn0", {30'b0, cnt0}, 32'd3);
    chk("sat_err_cnt_zn1", {30'b0, cnt1}, 32'd3);
    err_clr = 1'b1;
    send(1'b0, 4'b1000);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    chk("clr_with_illegal", {30'b0, cnt0}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_alone", {30'b0, cnt0}, 32'd0);

    // Throughput: 16 back-to-back mixed-mode transactions
    lat_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m = i[0];
      if (m) d = (i % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'b0001 << $urandom_range(0, 3);
      else   d = (i % 5 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      send(m, d);
      chk("tput_out_valid", {31'b0, ov0}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (2) step();
    lat_chk = 1'b0;
    chk("tput_drained", q.size(), 32'd0);

    // Asynchronous reset with the buffer full
    out_ready = 1'b0;
    send(1'b0, 4'b1100);
    send(1'b1, 4'b0011);
    in_mode = 1'b0;
    in_data = 4'h1;
    chk("pre_rst_full", {31'b0, in_ready0}, 32'd0);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, ov0}, 32'd0);
    chk("async_rst_out_data", {28'b0, od0}, 32'd0);
    chk("async_rst_out_err", {31'b0, oe0}, 32'd0);
    chk("async_rst_err_cnt", {30'b0, cnt0}, 32'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rel_in_ready", {31'b0, in_ready0}, 32'd1);
    repeat (3) step();
    chk("no_stale_out_valid", {31'b0, ov0}, 32'd0);
    chk("final_queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_onehot_conv.md
# bin_onehot_conv

Parametrised, pipelined binary/one-hot converter with valid/ready flow control. It converts a W-bit binary index to an N = 2**W one-hot vector, or converts a one-hot vector back to binary, selected per transaction. It flags and counts illegal inputs. It sits between decode/select logic and downstream consumers, and replaces ad-hoc combinational decoders wherever backpressure or error tracking is needed.

## Interface
Parameters:
- W, 2: binary index width. Derived localparam N = 2**W.
- ZERO_NULL, 0: if 1, binary index 0 maps to all-zero (null) and the all-zero one-hot input is legal.
- CW, 8: error counter width.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept
- in_mode  in  1  0 = bin→onehot, 1 = onehot→bin; sampled with in_data
- in_data  in  N  mode 0: index in [W-1:0], upper bits must be 0; mode 1: one-hot vector
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts
- out_data  out  N  mode 0: one-hot; mode 1: index zero-extended to N bits
- out_err  out  1  transaction was illegal; out_data is 0
- err_clr  in  1  synchronous clear of err_cnt
- err_cnt  out  CW  saturating count of accepted illegal transactions

## Operation
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- Mode 0:
  - Output bit in_data[W-1:0] is set.
  - If ZERO_NULL=1 and the index is 0, out_data = 0.
  - Any nonzero in_data[N-1:W] → out_err=1, out_data=0.
- Mode 1:
  - Exactly one bit set → index of that bit.
  - All-zero input is legal only when ZERO_NULL=1, and decodes to 0.
  - Otherwise (zero bits, or more than one bit set) → out_err=1, out_data=0.
- Buffer: output register plus one skid register. States:
  - EMPTY: no valid data.
  - ONE: output register valid.
  - TWO: output and skid registers both valid.
- State transitions:
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without transfer.
  - ONE→EMPTY on transfer without accept.
  - ONE stays ONE on simultaneous accept and transfer.
  - TWO→ONE on transfer; skid moves into the output register.
- in_ready = (state != TWO).
- Order is strictly preserved; no loss, no duplication.
- err_cnt:
  - Increments on accept of an illegal transaction.
  - Saturates at 2**CW-1; never wraps.
  - err_clr and an illegal accept in the same cycle → err_cnt = 1.
  - err_clr alone → 0.
- Reset (async, any time, including mid-transfer):
  - State EMPTY; out_valid=0, out_data=0, out_err=0, err_cnt=0; skid contents discarded.
  - in_ready=1 from the first edge after rst deasserts.

## Timing
- Latency: accept in cycle t → out_valid in cycle t+1, when the buffer is EMPTY or ONE with transfer.
- Throughput: one transaction per cycle when out_ready is held high.
- in_ready depends only on registered state; there is no combinational path out_ready→in_ready, and none in_*→out_*.
- out_data, out_err and out_valid are registered and hold stable while out_valid && !out_ready.
- err_cnt updates in the cycle after the accept edge, i.e. with the same timing as out_err.

## Structure
- Package bin_onehot_pkg holds:
  - mode constants MODE_B2O=1'b0, MODE_O2B=1'b1;
  - buffer state typedef {EMPTY, ONE, TWO};
  - pure functions for the N-width decode and encode, and the illegal-input check.
- Sub-module bin_onehot_skid: generic 2-entry valid/ready skid buffer parametrised on payload width (N+1 bits: data plus err).
- The top level holds the conversion logic, the error counter, and the skid instance.

## Test plan
- Reset: assert rst with the buffer in TWO → outputs immediately 0, err_cnt=0; in_ready=1 after release; held data never appears.
- Mode 0 (W=2), out_ready=1:
  - in 0x2 → out 4'b0100 one cycle later.
  - in 0x0 → 4'b0001 when ZERO_NULL=0; → 4'b0000 when ZERO_NULL=1.
  - in 4'b0101 → out_err=1, out_data=0, err_cnt=1.
- Mode 1 (W=2):
  - 4'b1000 → 4'b0011.
  - 4'b0110 → out_err=1, out_data=0.
  - 4'b0000 → err when ZERO_NULL=0; → 0 with no err when ZERO_NULL=1.
- Backpressure: out_ready=0, stream A,B,C → A and B accepted, in_ready=0 from the cycle after B's accept; raise out_ready → A,B,C emitted in order, once each.
- Counter (CW=2): 5 illegal accepts → err_cnt=3 (saturated); err_clr together with an illegal accept → 1; err_clr alone → 0.
- Throughput: out_ready=1, 16 back-to-back mixed-mode inputs → 16 consecutive out_valid cycles, 1-cycle latency, each result matching the reference model.
